// File: rtl/dm_pkg.sv
// Shared type codes, FSM encoding and helpers for the data-memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_pkg;

    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_BYTE  = 3'b010;
    localparam logic [2:0] DM_HALFU = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    typedef enum logic [1:0] {
        DM_IDLE = 2'b00,
        DM_BUSY = 2'b01,
        DM_RESP = 2'b10
    } dm_state_t;

    // Codes 101..111 are reserved and must be rejected.
    function automatic logic dm_legal_type(input logic [2:0] t);
        return (t <= DM_BYTEU);
    endfunction

endpackage

// File: rtl/dm_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Latency: n/a (wiring only).
// Backpressure: master holds req_* stable while req_valid && !req_ready.
interface dm_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_lane_fmt.sv
// Lane merge for stores, sign/zero extension for loads, misalignment detect.
// Latency: purely combinational.
// Backpressure: none.
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_type,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_merged,
    output logic [31:0] o_load,
    output logic        o_misal
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_lane[1] ? i_old[31:16] : i_old[15:0];
    assign w_byte = i_old[8*i_lane +: 8];

    // Unsigned store codes write exactly like their signed counterparts;
    // illegal codes leave the word untouched and load as zero.
    always_comb begin
        o_merged = i_old;
        o_load   = '0;
        o_misal  = 1'b0;
        case (i_type)
            DM_WORD: begin
                o_merged = i_wdata;
                o_load   = i_old;
                o_misal  = (i_lane != 2'b00);
            end
            DM_HALF, DM_HALFU: begin
                if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
                else           o_merged[15:0]  = i_wdata[15:0];
                o_load  = (i_type == DM_HALF) ? {{16{w_half[15]}}, w_half}
                                              : {16'h0000, w_half};
                o_misal = i_lane[0];
            end
            DM_BYTE, DM_BYTEU: begin
                o_merged[8*i_lane +: 8] = i_wdata[7:0];
                o_load = (i_type == DM_BYTE) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'h000000, w_byte};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Data memory: one load/store per transaction, programmable wait states,
// lane merge/extension and error flagging. Optional store trace: DM_TRACE_EN.
// Latency: resp_valid pulses LATENCY cycles after accept; req_ready low LATENCY+1 cycles.
// Backpressure: req_ready only in IDLE; requests seen elsewhere are ignored.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    dm_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [31:0]   r_mem [DEPTH];

    dm_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_type;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_ready;
    logic          r_resp_vld;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_old;
    logic [31:0]   w_merged;
    logic [31:0]   w_load;
    logic          w_misal;
    logic          w_oor;
    logic          w_err;
    logic          w_access;
    logic          w_commit;

    assign w_idx    = r_addr[AW+1:2];
    assign w_old    = r_mem[w_idx];
    assign w_oor    = ({2'b00, r_addr[31:2]} >= 32'(DEPTH));
    assign w_err    = w_misal | w_oor | ~dm_legal_type(r_type);
    assign w_access = (r_state == DM_BUSY) && (r_cnt == '0);
    assign w_commit = w_access && r_we && !w_err;

    dm_lane_fmt u_lane_fmt (
        .i_old    (w_old),
        .i_wdata  (r_wdata),
        .i_type   (r_type),
        .i_lane   (r_addr[1:0]),
        .o_merged (w_merged),
        .o_load   (w_load),
        .o_misal  (w_misal)
    );

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_vld;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    // Transaction FSM: capture, count wait states, access, pulse response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= DM_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_type     <= DM_WORD;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ready    <= 1'b1;
            r_resp_vld <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                DM_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_type  <= bus.req_type;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_ready <= 1'b0;
                        r_state <= DM_BUSY;
                    end
                end
                DM_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_err      <= w_err;
                        r_rdata    <= (r_we || w_err) ? 32'h0 : w_load;
                        r_resp_vld <= 1'b1;
                        r_state    <= DM_RESP;
                    end
                end
                DM_RESP: begin
                    r_resp_vld <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= DM_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= DM_IDLE;
                end
            endcase
        end
    end

    // Storage: cleared on reset, written once per legal store at the access edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] r_pc;

    // PC is only needed for the trace line, so it is captured only here.
    always_ff @(posedge clk) begin
        if (reset)                                         r_pc <= '0;
        else if (r_state == DM_IDLE && bus.req_valid)      r_pc <= bus.req_pc;
    end

    // Report every committed store with the full post-merge word.
    always_ff @(posedge clk) begin
        if (!reset && w_commit)
            $display("@%h: *%h <= %h", r_pc, r_addr, w_merged);
    end
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: one LATENCY=1 and one LATENCY=4 instance.
// Latency: checks response timing and ready-low window per instance.
// Backpressure: holds req_valid across busy windows to exercise ignore/hold.
module tb_dm_ctrl;
    import dm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        tb_sel = 1'b0;   // 0 -> LATENCY=1 instance, 1 -> LATENCY=4
    logic        tb_vld = 1'b0;
    logic        tb_we = 1'b0;
    logic [2:0]  tb_type = DM_WORD;
    logic [31:0] tb_addr = '0;
    logic [31:0] tb_wdata = '0;
    logic [31:0] tb_pc = '0;

    int n_chk = 0;
    int n_err = 0;

    dm_if bus1();
    dm_if bus4();

    assign bus1.req_valid = tb_vld && !tb_sel;
    assign bus1.req_we    = tb_we;
    assign bus1.req_type  = tb_type;
    assign bus1.req_addr  = tb_addr;
    assign bus1.req_wdata = tb_wdata;
    assign bus1.req_pc    = tb_pc;
    assign bus4.req_valid = tb_vld && tb_sel;
    assign bus4.req_we    = tb_we;
    assign bus4.req_type  = tb_type;
    assign bus4.req_addr  = tb_addr;
    assign bus4.req_wdata = tb_wdata;
    assign bus4.req_pc    = tb_pc;

    logic        w_rdy, w_rvld, w_err;
    logic [31:0] w_rdata;
    assign w_rdy   = tb_sel ? bus4.req_ready  : bus1.req_ready;
    assign w_rvld  = tb_sel ? bus4.resp_valid : bus1.resp_valid;
    assign w_err   = tb_sel ? bus4.resp_err   : bus1.resp_err;
    assign w_rdata = tb_sel ? bus4.resp_rdata : bus1.resp_rdata;

    dm_ctrl #(.DEPTH(1024), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dm_ctrl #(.DEPTH(1024), .LATENCY(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; returns response fields and accept-to-response cycles.
    task automatic xact(input logic s, input logic we, input logic [2:0] ty,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                        output logic [31:0] rd, output logic er, output int cyc);
        int n;
        @(negedge clk);
        tb_sel = s; tb_vld = 1'b1; tb_we = we; tb_type = ty;
        tb_addr = a; tb_wdata = wd; tb_pc = pc;
        n = 0;
        while (!w_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!w_rdy) chk("accept_timeout", 32'(w_rdy), 32'd1);
        @(posedge clk);
        #1 tb_vld = 1'b0;
        cyc = 0;
        while (cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (w_rvld) break;
        end
        if (!w_rvld) chk("resp_timeout", 32'(w_rvld), 32'd1);
        rd = w_rdata;
        er = w_err;
    endtask

    task automatic st(input string tag, input logic s, input logic [2:0] ty,
                      input logic [31:0] a, input logic [31:0] wd, input logic exp_er);
        logic [31:0] rd; logic er; int cyc;
        xact(s, 1'b1, ty, a, wd, 32'h0000_1000 + a, rd, er, cyc);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
        chk({tag, "_rd"}, rd, 32'h0);
    endtask

    task automatic ld(input string tag, input logic s, input logic [2:0] ty,
                      input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd; logic er; int cyc;
        xact(s, 1'b0, ty, a, 32'h0, 32'h0, rd, er, cyc);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
        chk({tag, "_rd"}, rd, exp_rd);
    endtask

    initial begin
        logic [31:0] rd; logic er; int cyc;
        int low, rv_at, n;
        logic seen;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready1", 32'(bus1.req_ready), 32'd1);
        chk("rst_ready4", 32'(bus4.req_ready), 32'd1);
        chk("rst_rvld1", 32'(bus1.resp_valid), 32'd0);
        chk("rst_err1", 32'(bus1.resp_err), 32'd0);
        chk("rst_rdata1", bus1.resp_rdata, 32'h0);

        // Word store/load with one-cycle response timing.
        xact(1'b0, 1'b1, DM_WORD, 32'h10, 32'hDEADBEEF, 32'h100, rd, er, cyc);
        chk("w_st_lat", 32'(cyc), 32'd1);
        chk("w_st_err", 32'(er), 32'd0);
        xact(1'b0, 1'b0, DM_WORD, 32'h10, 32'h0, 32'h104, rd, er, cyc);
        chk("w_ld_lat", 32'(cyc), 32'd1);
        chk("w_ld_rd", rd, 32'hDEADBEEF);
        chk("w_ld_err", 32'(er), 32'd0);

        // Lane merge and extension.
        st("m_w",  1'b0, DM_WORD, 32'h20, 32'h11223344, 1'b0);
        st("m_b",  1'b0, DM_BYTE, 32'h21, 32'hFFFFFFAA, 1'b0);
        ld("m_word",  1'b0, DM_WORD,  32'h20, 32'h1122AA44, 1'b0);
        ld("m_bs",    1'b0, DM_BYTE,  32'h21, 32'hFFFFFFAA, 1'b0);
        ld("m_bu",    1'b0, DM_BYTEU, 32'h21, 32'h000000AA, 1'b0);
        ld("m_hs_hi", 1'b0, DM_HALF,  32'h22, 32'h00001122, 1'b0);
        ld("m_hs_lo", 1'b0, DM_HALF,  32'h20, 32'hFFFFAA44, 1'b0);
        ld("m_hu_lo", 1'b0, DM_HALFU, 32'h20, 32'h0000AA44, 1'b0);
        st("m_hu_st", 1'b0, DM_HALFU, 32'h62, 32'h1234BEEF, 1'b0);
        ld("m_hu_chk", 1'b0, DM_WORD, 32'h60, 32'hBEEF0000, 1'b0);

        // Error cases.
        ld("e_wmis", 1'b0, DM_WORD, 32'h02, 32'h0, 1'b1);
        st("e_pre",  1'b0, DM_WORD, 32'h04, 32'h01020304, 1'b0);
        st("e_hmis", 1'b0, DM_HALF, 32'h05, 32'h0000FFFF, 1'b1);
        ld("e_hmis_chk", 1'b0, DM_WORD, 32'h04, 32'h01020304, 1'b0);
        ld("e_type", 1'b0, 3'b111, 32'h10, 32'h0, 1'b1);
        st("e_type_st", 1'b0, 3'b101, 32'h10, 32'h0, 1'b1);
        ld("e_type_chk", 1'b0, DM_WORD, 32'h10, 32'hDEADBEEF, 1'b0);
        ld("e_oor", 1'b0, DM_WORD, 32'h1000, 32'h0, 1'b1);
        st("e_oor_st", 1'b0, DM_WORD, 32'h1000, 32'h12345678, 1'b1);
        ld("e_oor_chk", 1'b0, DM_WORD, 32'h0, 32'h0, 1'b0);
        st("top_b", 1'b0, DM_BYTE, 32'hFFF, 32'h00000080, 1'b0);
        ld("top_bs", 1'b0, DM_BYTE, 32'hFFF, 32'hFFFFFF80, 1'b0);
        ld("top_w", 1'b0, DM_WORD, 32'hFFC, 32'h80000000, 1'b0);

        // Half store that would be traced: prior word 0, high lane.
        xact(1'b0, 1'b1, DM_HALF, 32'h32, 32'h0000BEEF, 32'h3004, rd, er, cyc);
        chk("tr_err", 32'(er), 32'd0);
        ld("tr_chk", 1'b0, DM_WORD, 32'h30, 32'hBEEF0000, 1'b0);

        // LATENCY=4 single transaction timing.
        xact(1'b1, 1'b1, DM_WORD, 32'h44, 32'h0BADF00D, 32'h0, rd, er, cyc);
        chk("l4_lat", 32'(cyc), 32'd4);
        ld("l4_ld", 1'b1, DM_WORD, 32'h44, 32'h0BADF00D, 1'b0);

        // LATENCY=4 back-to-back: valid held across the busy window.
        @(negedge clk);
        tb_sel = 1'b1; tb_vld = 1'b1; tb_we = 1'b1; tb_type = DM_WORD;
        tb_addr = 32'h40; tb_wdata = 32'hCAFEF00D;
        n = 0;
        while (!w_rdy && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 tb_we = 1'b0;
        low = 0; rv_at = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (w_rvld) rv_at = n;
            if (!w_rdy) low++;
        end while (!w_rdy && n < 20);
        chk("b2b_low", 32'(low), 32'd5);
        chk("b2b_rvld_at", 32'(rv_at), 32'd5);
        @(posedge clk);
        #1;
        chk("b2b_accept", 32'(w_rdy), 32'd0);
        tb_vld = 1'b0;
        cyc = 0;
        while (cyc < 50) begin
            @(posedge clk); #1; cyc++;
            if (w_rvld) break;
        end
        chk("b2b_lat", 32'(cyc), 32'd4);
        chk("b2b_rd", w_rdata, 32'hCAFEF00D);

        // Reset while BUSY aborts the store and suppresses the response.
        @(negedge clk);
        tb_sel = 1'b1; tb_vld = 1'b1; tb_we = 1'b1; tb_type = DM_WORD;
        tb_addr = 32'h50; tb_wdata = 32'h00000055;
        n = 0;
        while (!w_rdy && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 tb_vld = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= w_rvld; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ready", 32'(w_rdy), 32'd1);
        repeat (8) begin @(negedge clk); seen |= w_rvld; end
        chk("rst_mid_norvld", 32'(seen), 32'd0);
        ld("rst_mid_ld", 1'b1, DM_WORD, 32'h50, 32'h0, 1'b0);
        ld("rst_clr1", 1'b0, DM_WORD, 32'h10, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
